// File: rtl/core_decode_stage.sv
// RV32I decode stage: combinational decoder feeding a registered output
// slot plus one skid entry, so in_ready_o is a flop and no bubbles occur.
module core_decode_stage #(
    parameter int XLEN       = 32,
    parameter int ADDR_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALU_OP_W   = 4,
    parameter int LIS_OP_W   = 3,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [31:0]           instr_i,
    input  logic [ADDR_W-1:0]     pc_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [ALU_OP_W-1:0]   alu_op_o,
    output logic [LIS_OP_W-1:0]   lis_op_o,
    output logic [2:0]            br_funct3_o,
    output logic [XLEN-1:0]       imm_val_rs1_o,
    output logic [XLEN-1:0]       imm_val_rs2_o,
    output logic [ADDR_W-1:0]     tgt_o,
    output logic [REG_ADDR_W-1:0] rs1_addr_o,
    output logic [REG_ADDR_W-1:0] rs2_addr_o,
    output logic [REG_ADDR_W-1:0] rd_addr_o,
    output logic [7:0]            ctrl_o,
    output logic [CNT_W-1:0]      dec_cnt_o
);

    localparam logic [ALU_OP_W-1:0] ALU_ADD  = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] ALU_SLL  = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] ALU_SLT  = ALU_OP_W'(3);
    localparam logic [ALU_OP_W-1:0] ALU_SLTU = ALU_OP_W'(4);
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = ALU_OP_W'(5);
    localparam logic [ALU_OP_W-1:0] ALU_SRL  = ALU_OP_W'(6);
    localparam logic [ALU_OP_W-1:0] ALU_SRA  = ALU_OP_W'(7);
    localparam logic [ALU_OP_W-1:0] ALU_OR   = ALU_OP_W'(8);
    localparam logic [ALU_OP_W-1:0] ALU_AND  = ALU_OP_W'(9);

    localparam logic [LIS_OP_W-1:0] LIS_LB  = LIS_OP_W'(0);
    localparam logic [LIS_OP_W-1:0] LIS_LH  = LIS_OP_W'(1);
    localparam logic [LIS_OP_W-1:0] LIS_LW  = LIS_OP_W'(2);
    localparam logic [LIS_OP_W-1:0] LIS_LBU = LIS_OP_W'(3);
    localparam logic [LIS_OP_W-1:0] LIS_LHU = LIS_OP_W'(4);
    localparam logic [LIS_OP_W-1:0] LIS_SB  = LIS_OP_W'(5);
    localparam logic [LIS_OP_W-1:0] LIS_SH  = LIS_OP_W'(6);
    localparam logic [LIS_OP_W-1:0] LIS_SW  = LIS_OP_W'(7);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    typedef struct packed {
        logic [ALU_OP_W-1:0]   alu_op;
        logic [LIS_OP_W-1:0]   lis_op;
        logic [2:0]            br_f3;
        logic [XLEN-1:0]       imm1;
        logic [XLEN-1:0]       imm2;
        logic [ADDR_W-1:0]     tgt;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic [7:0]            ctrl;
    } dec_t;

    logic [6:0]            opc;
    logic [2:0]            f3;
    logic [6:0]            f7;
    logic [REG_ADDR_W-1:0] rs1_f;
    logic [REG_ADDR_W-1:0] rs2_f;
    logic [REG_ADDR_W-1:0] rd_f;
    logic signed [31:0]    imm_i;
    logic signed [31:0]    imm_s;
    logic signed [31:0]    imm_b;
    logic signed [31:0]    imm_u;
    logic signed [31:0]    imm_j;
    logic [ADDR_W-1:0]     off_b;
    logic [ADDR_W-1:0]     off_j;

    assign opc   = instr_i[6:0];
    assign f3    = instr_i[14:12];
    assign f7    = instr_i[31:25];
    assign rs1_f = REG_ADDR_W'(instr_i[19:15]);
    assign rs2_f = REG_ADDR_W'(instr_i[24:20]);
    assign rd_f  = REG_ADDR_W'(instr_i[11:7]);
    assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                    instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u = {instr_i[31:12], 12'h000};
    assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                    instr_i[20], instr_i[30:21], 1'b0};
    assign off_b = ADDR_W'(imm_b);
    assign off_j = ADDR_W'(imm_j);

    dec_t dec;
    logic ill;
    logic jmp;
    logic br;
    logic reg_w;
    logic mem_w;
    logic ls;
    logic imm1_en;
    logic imm2_en;

    always_comb begin
        dec     = '0;
        ill     = 1'b0;
        jmp     = 1'b0;
        br      = 1'b0;
        reg_w   = 1'b0;
        mem_w   = 1'b0;
        ls      = 1'b0;
        imm1_en = 1'b0;
        imm2_en = 1'b0;
        if (instr_i[1:0] != 2'b11) begin
            ill = 1'b1;
        end else begin
            case (opc)
                OPC_LUI: begin
                    dec.imm2 = XLEN'(imm_u);
                    imm2_en  = 1'b1;
                    reg_w    = 1'b1;
                end
                OPC_AUIPC: begin
                    dec.imm1 = XLEN'(pc_i);
                    dec.imm2 = XLEN'(imm_u);
                    imm1_en  = 1'b1;
                    imm2_en  = 1'b1;
                    reg_w    = 1'b1;
                end
                OPC_JAL, OPC_JALR: begin
                    // Execute computes the link value pc+4; target is separate
                    dec.imm1 = XLEN'(pc_i);
                    dec.imm2 = XLEN'(4);
                    imm1_en  = 1'b1;
                    imm2_en  = 1'b1;
                    jmp      = 1'b1;
                    reg_w    = 1'b1;
                    if (opc == OPC_JAL) begin
                        dec.tgt = pc_i + off_j;
                    end else begin
                        dec.rs1 = rs1_f;
                        dec.tgt = ADDR_W'(imm_i);
                    end
                end
                OPC_BRANCH: begin
                    if (f3 == 3'd2 || f3 == 3'd3) begin
                        ill = 1'b1;
                    end else begin
                        br        = 1'b1;
                        dec.br_f3 = f3;
                        dec.rs1   = rs1_f;
                        dec.rs2   = rs2_f;
                        dec.tgt   = pc_i + off_b;
                    end
                end
                OPC_LOAD: begin
                    dec.rs1  = rs1_f;
                    dec.imm2 = XLEN'(imm_i);
                    imm2_en  = 1'b1;
                    ls       = 1'b1;
                    reg_w    = 1'b1;
                    case (f3)
                        3'd0:    dec.lis_op = LIS_LB;
                        3'd1:    dec.lis_op = LIS_LH;
                        3'd2:    dec.lis_op = LIS_LW;
                        3'd4:    dec.lis_op = LIS_LBU;
                        3'd5:    dec.lis_op = LIS_LHU;
                        default: ill = 1'b1;
                    endcase
                end
                OPC_STORE: begin
                    dec.rs1  = rs1_f;
                    dec.rs2  = rs2_f;
                    dec.imm2 = XLEN'(imm_s);
                    imm2_en  = 1'b1;
                    ls       = 1'b1;
                    mem_w    = 1'b1;
                    case (f3)
                        3'd0:    dec.lis_op = LIS_SB;
                        3'd1:    dec.lis_op = LIS_SH;
                        3'd2:    dec.lis_op = LIS_SW;
                        default: ill = 1'b1;
                    endcase
                end
                OPC_OPIMM, OPC_OP: begin
                    dec.rs1 = rs1_f;
                    reg_w   = 1'b1;
                    if (opc == OPC_OPIMM) begin
                        dec.imm2 = XLEN'(imm_i);
                        imm2_en  = 1'b1;
                    end else begin
                        dec.rs2 = rs2_f;
                    end
                    case (f3)
                        3'd0: dec.alu_op = (opc == OPC_OP && f7[5])
                                           ? ALU_SUB : ALU_ADD;
                        3'd1: dec.alu_op = ALU_SLL;
                        3'd2: dec.alu_op = ALU_SLT;
                        3'd3: dec.alu_op = ALU_SLTU;
                        3'd4: dec.alu_op = ALU_XOR;
                        3'd5: dec.alu_op = f7[5] ? ALU_SRA : ALU_SRL;
                        3'd6: dec.alu_op = ALU_OR;
                        default: dec.alu_op = ALU_AND;
                    endcase
                    // Shifts use imm[11:5] as a funct7; OP always does
                    if (opc == OPC_OP || f3 == 3'd1 || f3 == 3'd5) begin
                        if (f7 != 7'h00 && f7 != 7'h20) ill = 1'b1;
                        if (f7 == 7'h20 && f3 != 3'd5 &&
                            !(opc == OPC_OP && f3 == 3'd0)) ill = 1'b1;
                    end
                end
                OPC_FENCE: begin
                end
                default: ill = 1'b1;
            endcase
        end
        if (rd_f == '0) reg_w = 1'b0;
        dec.rd = reg_w ? rd_f : '0;
        if (ill) begin
            dec      = '0;
            dec.ctrl = 8'h80;
        end else begin
            dec.ctrl = {1'b0, jmp, br, reg_w, mem_w, ls, imm2_en, imm1_en};
        end
    end

    dec_t             out_q, out_d;
    dec_t             skid_q, skid_d;
    logic             out_vld_q, out_vld_d;
    logic             skid_vld_q, skid_vld_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             acc;
    logic             cons;

    assign acc  = in_valid_i & ~skid_vld_q;
    assign cons = out_vld_q & out_ready_i;

    always_comb begin
        out_d      = out_q;
        out_vld_d  = out_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        cnt_d      = cnt_q;
        if (flush_i) begin
            out_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
        end else begin
            if (cons) cnt_d = cnt_q + CNT_W'(1);
            if (!out_vld_q || out_ready_i) begin
                if (skid_vld_q) begin
                    out_d      = skid_q;
                    out_vld_d  = 1'b1;
                    skid_vld_d = 1'b0;
                end else if (acc) begin
                    out_d     = dec;
                    out_vld_d = 1'b1;
                end else begin
                    out_vld_d = 1'b0;
                end
            end else if (acc) begin
                skid_d     = dec;
                skid_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q      <= '0;
            skid_q     <= '0;
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            out_q      <= out_d;
            skid_q     <= skid_d;
            out_vld_q  <= out_vld_d;
            skid_vld_q <= skid_vld_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready_o    = ~skid_vld_q;
    assign out_valid_o   = out_vld_q;
    assign alu_op_o      = out_q.alu_op;
    assign lis_op_o      = out_q.lis_op;
    assign br_funct3_o   = out_q.br_f3;
    assign imm_val_rs1_o = out_q.imm1;
    assign imm_val_rs2_o = out_q.imm2;
    assign tgt_o         = out_q.tgt;
    assign rs1_addr_o    = out_q.rs1;
    assign rs2_addr_o    = out_q.rs2;
    assign rd_addr_o     = out_q.rd;
    assign ctrl_o        = out_q.ctrl;
    assign dec_cnt_o     = cnt_q;

endmodule

// File: tb/tb_core_decode_stage.sv
// Directed bench for core_decode_stage: decode vectors, skid/stall,
// flush, mid-run reset and counter wrap (CNT_W reduced to 4).
module tb_core_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] instr_i;
    logic [31:0] pc_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [3:0]  alu_op_o;
    logic [2:0]  lis_op_o;
    logic [2:0]  br_funct3_o;
    logic [31:0] imm_val_rs1_o;
    logic [31:0] imm_val_rs2_o;
    logic [31:0] tgt_o;
    logic [4:0]  rs1_addr_o;
    logic [4:0]  rs2_addr_o;
    logic [4:0]  rd_addr_o;
    logic [7:0]  ctrl_o;
    logic [3:0]  dec_cnt_o;

    int n_cmp = 0;
    int n_fail = 0;

    core_decode_stage #(.CNT_W(4)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .instr_i(instr_i), .pc_i(pc_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .alu_op_o(alu_op_o), .lis_op_o(lis_op_o),
        .br_funct3_o(br_funct3_o),
        .imm_val_rs1_o(imm_val_rs1_o), .imm_val_rs2_o(imm_val_rs2_o),
        .tgt_o(tgt_o), .rs1_addr_o(rs1_addr_o),
        .rs2_addr_o(rs2_addr_o), .rd_addr_o(rd_addr_o),
        .ctrl_o(ctrl_o), .dec_cnt_o(dec_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] pc);
        in_valid_i = 1'b1;
        instr_i    = ins;
        pc_i       = pc;
        step();
        in_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_cmp++; if (out_valid_o !== 1'b0) begin n_fail++;
            $display("FAIL rst_valid got %b exp 0", out_valid_o); end
        n_cmp++; if (ctrl_o !== 8'h00) begin n_fail++;
            $display("FAIL rst_ctrl got %h exp 00", ctrl_o); end
        n_cmp++; if (dec_cnt_o !== 4'd0) begin n_fail++;
            $display("FAIL rst_cnt got %0d exp 0", dec_cnt_o); end
        n_cmp++; if (imm_val_rs2_o !== 32'h0 || tgt_o !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_data got %h/%h exp 0", imm_val_rs2_o, tgt_o); end
        step();
        n_cmp++; if (in_ready_o !== 1'b1) begin n_fail++;
            $display("FAIL rst_ready got %b exp 1", in_ready_o); end
    endtask

    task automatic test_addi();
        send(32'h00500093, 32'h0);
        n_cmp++; if (out_valid_o !== 1'b1) begin n_fail++;
            $display("FAIL addi_valid got %b exp 1", out_valid_o); end
        n_cmp++; if (alu_op_o !== 4'd0) begin n_fail++;
            $display("FAIL addi_alu got %0d exp 0", alu_op_o); end
        n_cmp++; if (imm_val_rs2_o !== 32'd5) begin n_fail++;
            $display("FAIL addi_imm got %h exp 5", imm_val_rs2_o); end
        n_cmp++; if (rd_addr_o !== 5'd1 || rs1_addr_o !== 5'd0) begin
            n_fail++;
            $display("FAIL addi_regs got rd %0d rs1 %0d exp 1 0",
                     rd_addr_o, rs1_addr_o); end
        n_cmp++; if (ctrl_o !== 8'h12) begin n_fail++;
            $display("FAIL addi_ctrl got %h exp 12", ctrl_o); end
        step();
        n_cmp++; if (out_valid_o !== 1'b0) begin n_fail++;
            $display("FAIL addi_drain got %b exp 0", out_valid_o); end
    endtask

    task automatic test_lui();
        send(32'h12345137, 32'h40);
        n_cmp++; if (imm_val_rs2_o !== 32'h12345000) begin n_fail++;
            $display("FAIL lui_imm got %h exp 12345000", imm_val_rs2_o); end
        n_cmp++; if (rs1_addr_o !== 5'd0 || rd_addr_o !== 5'd2) begin
            n_fail++;
            $display("FAIL lui_regs got rs1 %0d rd %0d exp 0 2",
                     rs1_addr_o, rd_addr_o); end
        n_cmp++; if (ctrl_o !== 8'h12) begin n_fail++;
            $display("FAIL lui_ctrl got %h exp 12", ctrl_o); end
        step();
    endtask

    task automatic test_jal();
        send(32'h008000EF, 32'h100);
        n_cmp++; if (tgt_o !== 32'h108) begin n_fail++;
            $display("FAIL jal_tgt got %h exp 108", tgt_o); end
        n_cmp++; if (imm_val_rs1_o !== 32'h100 || imm_val_rs2_o !== 32'd4)
        begin n_fail++;
            $display("FAIL jal_imm got %h %h exp 100 4",
                     imm_val_rs1_o, imm_val_rs2_o); end
        n_cmp++; if (ctrl_o !== 8'h53 || rd_addr_o !== 5'd1) begin
            n_fail++;
            $display("FAIL jal_ctrl got %h rd %0d exp 53 1",
                     ctrl_o, rd_addr_o); end
        step();
    endtask

    task automatic test_sw();
        send(32'h00512623, 32'h0);
        n_cmp++; if (ctrl_o !== 8'h0E) begin n_fail++;
            $display("FAIL sw_ctrl got %h exp 0e", ctrl_o); end
        n_cmp++; if (lis_op_o !== 3'd7) begin n_fail++;
            $display("FAIL sw_lis got %0d exp 7", lis_op_o); end
        n_cmp++; if (imm_val_rs2_o !== 32'd12) begin n_fail++;
            $display("FAIL sw_imm got %h exp c", imm_val_rs2_o); end
        n_cmp++; if (rs1_addr_o !== 5'd2 || rs2_addr_o !== 5'd5) begin
            n_fail++;
            $display("FAIL sw_regs got %0d %0d exp 2 5",
                     rs1_addr_o, rs2_addr_o); end
        step();
    endtask

    task automatic test_branch_load();
        send(32'h00208463, 32'h200);
        n_cmp++; if (tgt_o !== 32'h208 || ctrl_o !== 8'h20) begin
            n_fail++;
            $display("FAIL beq got tgt %h ctrl %h exp 208 20",
                     tgt_o, ctrl_o); end
        n_cmp++; if (rs1_addr_o !== 5'd1 || rs2_addr_o !== 5'd2 ||
                     rd_addr_o !== 5'd0 || br_funct3_o !== 3'd0) begin
            n_fail++;
            $display("FAIL beq_regs got %0d %0d %0d exp 1 2 0",
                     rs1_addr_o, rs2_addr_o, rd_addr_o); end
        send(32'hFFC12183, 32'h0);
        n_cmp++; if (imm_val_rs2_o !== 32'hFFFFFFFC) begin n_fail++;
            $display("FAIL lw_imm got %h exp fffffffc", imm_val_rs2_o); end
        n_cmp++; if (ctrl_o !== 8'h16 || lis_op_o !== 3'd2) begin
            n_fail++;
            $display("FAIL lw_ctrl got %h lis %0d exp 16 2",
                     ctrl_o, lis_op_o); end
        step();
    endtask

    task automatic test_op();
        send(32'h402081B3, 32'h0);
        n_cmp++; if (alu_op_o !== 4'd1 || ctrl_o !== 8'h10) begin
            n_fail++;
            $display("FAIL sub got alu %0d ctrl %h exp 1 10",
                     alu_op_o, ctrl_o); end
        send(32'h4030D093, 32'h0);
        n_cmp++; if (alu_op_o !== 4'd7 || ctrl_o !== 8'h12) begin
            n_fail++;
            $display("FAIL srai got alu %0d ctrl %h exp 7 12",
                     alu_op_o, ctrl_o); end
        send(32'h00000013, 32'h0);
        n_cmp++; if (ctrl_o !== 8'h02 || rd_addr_o !== 5'd0) begin
            n_fail++;
            $display("FAIL rd0 got ctrl %h exp 02", ctrl_o); end
        send(32'h0000000F, 32'h0);
        n_cmp++; if (ctrl_o !== 8'h00 || out_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL fence got ctrl %h exp 00", ctrl_o); end
        step();
    endtask

    task automatic test_illegal();
        send(32'hFFFFFFFF, 32'h0);
        n_cmp++; if (ctrl_o !== 8'h80 || rd_addr_o !== 5'd0) begin
            n_fail++;
            $display("FAIL ill_ones got ctrl %h exp 80", ctrl_o); end
        send(32'h00000073, 32'h0);
        n_cmp++; if (ctrl_o !== 8'h80) begin n_fail++;
            $display("FAIL ill_sys got %h exp 80", ctrl_o); end
        send(32'h022081B3, 32'h0);
        n_cmp++; if (ctrl_o !== 8'h80) begin n_fail++;
            $display("FAIL ill_f7 got %h exp 80", ctrl_o); end
        send(32'h4020C1B3, 32'h0);
        n_cmp++; if (ctrl_o !== 8'h80) begin n_fail++;
            $display("FAIL ill_xor20 got %h exp 80", ctrl_o); end
        send(32'h00003003, 32'h0);
        n_cmp++; if (ctrl_o !== 8'h80) begin n_fail++;
            $display("FAIL ill_ld3 got %h exp 80", ctrl_o); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] q [3];
        int idx = 0;
        q[0] = 32'h00100093;
        q[1] = 32'h00200093;
        q[2] = 32'h00300093;
        out_ready_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid_i = 1'b1;
            instr_i    = q[idx];
            if (in_ready_o) idx++;
            step();
        end
        n_cmp++; if (idx !== 2) begin n_fail++;
            $display("FAIL b2b_accepted got %0d exp 2", idx); end
        n_cmp++; if (in_ready_o !== 1'b0) begin n_fail++;
            $display("FAIL b2b_ready got %b exp 0", in_ready_o); end
        n_cmp++; if (out_valid_o !== 1'b1 || imm_val_rs2_o !== 32'd1) begin
            n_fail++;
            $display("FAIL b2b_hold got %h exp 1", imm_val_rs2_o); end
        out_ready_i = 1'b1;
        step();
        n_cmp++; if (out_valid_o !== 1'b1 || imm_val_rs2_o !== 32'd2) begin
            n_fail++;
            $display("FAIL b2b_second got %h exp 2", imm_val_rs2_o); end
        step();
        in_valid_i = 1'b0;
        n_cmp++; if (out_valid_o !== 1'b1 || imm_val_rs2_o !== 32'd3) begin
            n_fail++;
            $display("FAIL b2b_third got %h exp 3", imm_val_rs2_o); end
        step();
        n_cmp++; if (out_valid_o !== 1'b0) begin n_fail++;
            $display("FAIL b2b_empty got %b exp 0", out_valid_o); end
    endtask

    task automatic test_flush();
        out_ready_i = 1'b0;
        send(32'h00100093, 32'h0);
        send(32'h00200093, 32'h0);
        n_cmp++; if (in_ready_o !== 1'b0) begin n_fail++;
            $display("FAIL flush_full got %b exp 0", in_ready_o); end
        flush_i    = 1'b1;
        in_valid_i = 1'b1;
        instr_i    = 32'h00900093;
        step();
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        n_cmp++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_now got v %b r %b exp 0 1",
                     out_valid_o, in_ready_o); end
        step();
        n_cmp++; if (out_valid_o !== 1'b0) begin n_fail++;
            $display("FAIL flush_drop got %b exp 0", out_valid_o); end
    endtask

    task automatic test_reset_mid();
        out_ready_i = 1'b0;
        send(32'h00100093, 32'h0);
        send(32'h00200093, 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ready_i = 1'b1;
        n_cmp++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 ||
                     ctrl_o !== 8'h00 || dec_cnt_o !== 4'd0) begin
            n_fail++;
            $display("FAIL rstmid got v %b r %b c %h n %0d exp 0 1 00 0",
                     out_valid_o, in_ready_o, ctrl_o, dec_cnt_o); end
        step();
        n_cmp++; if (out_valid_o !== 1'b0) begin n_fail++;
            $display("FAIL rstmid_lost got %b exp 0", out_valid_o); end
    endtask

    task automatic test_counter_wrap();
        out_ready_i = 1'b1;
        for (int k = 0; k < 16; k++) begin
            in_valid_i = 1'b1;
            instr_i    = (32'(k) << 20) | 32'h00000093;
            step();
            n_cmp++; if (out_valid_o !== 1'b1 ||
                         imm_val_rs2_o !== 32'(k)) begin n_fail++;
                $display("FAIL stream_%0d got %h exp %h",
                         k, imm_val_rs2_o, 32'(k)); end
        end
        in_valid_i = 1'b0;
        n_cmp++; if (dec_cnt_o !== 4'd15) begin n_fail++;
            $display("FAIL cnt_15 got %0d exp 15", dec_cnt_o); end
        step();
        n_cmp++; if (dec_cnt_o !== 4'd0 || out_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL cnt_wrap got %0d exp 0", dec_cnt_o); end
        send(32'h00100093, 32'h0);
        step();
        n_cmp++; if (dec_cnt_o !== 4'd1) begin n_fail++;
            $display("FAIL cnt_after got %0d exp 1", dec_cnt_o); end
    endtask

    initial begin
        rst         = 1'b1;
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        instr_i     = 32'h0;
        pc_i        = 32'h0;
        out_ready_i = 1'b1;
        test_reset();
        test_addi();
        test_lui();
        test_jal();
        test_sw();
        test_branch_load();
        test_op();
        test_illegal();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_counter_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
